// File: rtl/buff_uart_pkg.sv
// ----------------------------------------------------------------------------
// buff_uart_pkg
// Shared definitions for the buff_uart stream bridge:
//   - bridge_state_t : polling / transfer FSM state encoding
//   - DEFAULT_*      : buff_uart register map (RX data, TX data, status)
//   - *_BIT          : status register bit positions
// ----------------------------------------------------------------------------
package buff_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STAT_REQ  = 3'd1,
        ST_STAT_WAIT = 3'd2,
        ST_DECIDE    = 3'd3,
        ST_RX_REQ    = 3'd4,
        ST_RX_WAIT   = 3'd5,
        ST_TX_PUSH   = 3'd6
    } bridge_state_t;

    localparam int DEFAULT_RX_ADDRESS     = 3;
    localparam int DEFAULT_TX_ADDRESS     = 4;
    localparam int DEFAULT_STATUS_ADDRESS = 5;

    localparam int DEFAULT_TX_FULL_BIT    = 0;
    localparam int DEFAULT_RX_AVAIL_BIT   = 1;

endpackage

// File: rtl/buff_uart_bridge_hold.sv
// ----------------------------------------------------------------------------
// buff_uart_bridge_hold
// One-entry valid/ready holding register.
//   clock, resetn          : clock / asynchronous active-low reset
//   wr_data, wr_valid      : entry load side
//   wr_ready               : high while the entry is empty
//   rd_data, rd_valid      : held entry (data stays put until drained)
//   rd_ready               : drains the entry when rd_valid is high
// A load and a drain never coincide: loads need the entry empty, drains
// need it full.
// ----------------------------------------------------------------------------
module buff_uart_bridge_hold #(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [width-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [width-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    logic [width-1:0] data_reg;
    logic             valid_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (valid_reg && rd_ready) begin
            // Data is left in place; only the valid flag drops.
            valid_reg <= 1'b0;
        end else if (wr_valid && !valid_reg) begin
            data_reg  <= wr_data;
            valid_reg <= 1'b1;
        end
    end

    assign wr_ready = !valid_reg;
    assign rd_data  = data_reg;
    assign rd_valid = valid_reg;

endmodule

// File: rtl/buff_uart_bridge.sv
// ----------------------------------------------------------------------------
// buff_uart_bridge
// Bridges a byte stream pair onto buff_uart's address/strobe register bus.
// The bridge polls the status register, then performs at most one transfer
// (RX read preferred over TX push) per poll.
//   clock, resetn                 : clock / asynchronous active-low reset
//   s_data, s_valid, s_ready      : TX byte stream in
//   m_data, m_valid, m_ready      : RX byte stream out
//   uart_active_address           : register address, valid with a strobe
//   uart_read_enable              : buff_uart takes uart_data_in (TX push)
//   uart_write_enable             : buff_uart drives uart_data_out (read)
//   uart_data_in                  : byte pushed to buff_uart
//   uart_data_out                 : read data, valid the cycle after strobe
// ----------------------------------------------------------------------------
module buff_uart_bridge
    import buff_uart_pkg::*;
#(
    parameter int width          = 8,
    parameter int addr_width     = 8,
    parameter int rx_address     = DEFAULT_RX_ADDRESS,
    parameter int tx_address     = DEFAULT_TX_ADDRESS,
    parameter int status_address = DEFAULT_STATUS_ADDRESS,
    parameter int tx_full_bit    = DEFAULT_TX_FULL_BIT,
    parameter int rx_avail_bit   = DEFAULT_RX_AVAIL_BIT,
    parameter int poll_gap       = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [width-1:0]      s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [width-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [addr_width-1:0] uart_active_address,
    output logic                  uart_read_enable,
    output logic                  uart_write_enable,
    output logic [width-1:0]      uart_data_in,
    input  logic [width-1:0]      uart_data_out
);

    localparam int               CNT_W   = (poll_gap > 0) ? $clog2(poll_gap + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(poll_gap);

    bridge_state_t         state_reg;
    logic [CNT_W-1:0]      poll_cnt_reg;
    logic                  stat_tx_full_reg;
    logic                  stat_rx_avail_reg;
    logic [addr_width-1:0] address_reg;
    logic                  read_enable_reg;
    logic                  write_enable_reg;
    logic [width-1:0]      data_in_reg;

    logic                  tx_empty;
    logic                  tx_full;
    logic [width-1:0]      tx_data;
    logic                  rx_empty;
    logic                  tx_pop;
    logic                  rx_load;

    // tx_hold drains on the edge that ends the push strobe cycle; rx_hold
    // loads on the edge that ends the cycle after the RX read strobe.
    assign tx_pop  = (state_reg == ST_TX_PUSH);
    assign rx_load = (state_reg == ST_RX_WAIT);

    buff_uart_bridge_hold #(.width(width)) u_tx_hold (
        .clock    (clock),
        .resetn   (resetn),
        .wr_data  (s_data),
        .wr_valid (s_valid),
        .wr_ready (tx_empty),
        .rd_data  (tx_data),
        .rd_valid (tx_full),
        .rd_ready (tx_pop)
    );

    buff_uart_bridge_hold #(.width(width)) u_rx_hold (
        .clock    (clock),
        .resetn   (resetn),
        .wr_data  (uart_data_out),
        .wr_valid (rx_load),
        .wr_ready (rx_empty),
        .rd_data  (m_data),
        .rd_valid (m_valid),
        .rd_ready (m_ready)
    );

    // Gated with resetn so upstream sees not-ready throughout reset.
    assign s_ready = tx_empty & resetn;

    // Bus outputs are registered and set on the transition into the state
    // that owns the strobe, so each strobe lasts exactly that one state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg         <= ST_IDLE;
            poll_cnt_reg      <= '0;
            stat_tx_full_reg  <= 1'b0;
            stat_rx_avail_reg <= 1'b0;
            address_reg       <= '0;
            read_enable_reg   <= 1'b0;
            write_enable_reg  <= 1'b0;
            data_in_reg       <= '0;
        end else begin
            read_enable_reg  <= 1'b0;
            write_enable_reg <= 1'b0;
            address_reg      <= '0;
            data_in_reg      <= '0;

            case (state_reg)
                ST_IDLE: begin
                    if (poll_cnt_reg == CNT_MAX) begin
                        // Only poll when a transfer could follow.
                        if (tx_full || rx_empty) begin
                            state_reg        <= ST_STAT_REQ;
                            write_enable_reg <= 1'b1;
                            address_reg      <= addr_width'(status_address);
                        end
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg + CNT_W'(1);
                    end
                end

                ST_STAT_REQ: begin
                    state_reg <= ST_STAT_WAIT;
                end

                ST_STAT_WAIT: begin
                    stat_tx_full_reg  <= uart_data_out[tx_full_bit];
                    stat_rx_avail_reg <= uart_data_out[rx_avail_bit];
                    state_reg         <= ST_DECIDE;
                end

                ST_DECIDE: begin
                    // RX first so buff_uart's receive buffer cannot overflow
                    // while a TX byte waits.
                    if (stat_rx_avail_reg && rx_empty) begin
                        state_reg        <= ST_RX_REQ;
                        write_enable_reg <= 1'b1;
                        address_reg      <= addr_width'(rx_address);
                    end else if (tx_full && !stat_tx_full_reg) begin
                        state_reg       <= ST_TX_PUSH;
                        read_enable_reg <= 1'b1;
                        address_reg     <= addr_width'(tx_address);
                        data_in_reg     <= tx_data;
                    end else begin
                        state_reg    <= ST_IDLE;
                        poll_cnt_reg <= '0;
                    end
                end

                ST_RX_REQ: begin
                    state_reg <= ST_RX_WAIT;
                end

                ST_RX_WAIT: begin
                    state_reg <= ST_IDLE;
                end

                ST_TX_PUSH: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_active_address = address_reg;
    assign uart_read_enable    = read_enable_reg;
    assign uart_write_enable   = write_enable_reg;
    assign uart_data_in        = data_in_reg;

endmodule

// File: tb/tb_buff_uart_bridge.sv
// ----------------------------------------------------------------------------
// tb_buff_uart_bridge
// Directed bench for buff_uart_bridge. A small buff_uart model answers the
// register bus: in loopback mode it serialises pushed bytes onto a line at
// 48 clocks per bit (460800 Hz / 9600 baud) and deserialises them back into
// an RX queue; in stub mode the status and RX data come from bench variables.
// ----------------------------------------------------------------------------
module tb_buff_uart_bridge;

    localparam int BAUD_DIV = 48;
    localparam int POLL_GAP = 2;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] uart_active_address;
    logic       uart_read_enable;
    logic       uart_write_enable;
    logic [7:0] uart_data_in;
    logic [7:0] uart_data_out = 8'h00;

    buff_uart_bridge dut (
        .clock               (clock),
        .resetn              (resetn),
        .s_data              (s_data),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .m_data              (m_data),
        .m_valid             (m_valid),
        .m_ready             (m_ready),
        .uart_active_address (uart_active_address),
        .uart_read_enable    (uart_read_enable),
        .uart_write_enable   (uart_write_enable),
        .uart_data_in        (uart_data_in),
        .uart_data_out       (uart_data_out)
    );

    always #5 clock = ~clock;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- buff_uart model ----------------
    logic       stub_mode   = 1'b0;
    logic [7:0] stub_status = 8'h00;
    logic [7:0] stub_rx     = 8'h00;

    logic       tx_buf_valid = 1'b0;
    logic [7:0] tx_buf       = 8'h00;
    logic [9:0] tx_sh        = 10'h3ff;
    int         tx_bits      = 0;
    int         tx_tick      = 0;
    logic       line         = 1'b1;
    logic       rx_busy      = 1'b0;
    int         rx_tick      = 0;
    int         rx_k         = 0;
    logic [9:0] rx_frame     = 10'h0;
    logic [9:0] last_frame   = 10'h0;
    int         frames       = 0;
    logic [7:0] rx_q[$];

    function automatic logic [7:0] status_word();
        logic [7:0] s;
        if (stub_mode) begin
            s = stub_status;
        end else begin
            s    = 8'h00;
            s[0] = tx_buf_valid;
            s[1] = (rx_q.size() != 0);
        end
        return s;
    endfunction

    always @(posedge clock) begin
        if (uart_write_enable) begin
            if (uart_active_address == 8'd5) begin
                uart_data_out <= status_word();
            end else if (uart_active_address == 8'd3) begin
                if (stub_mode) uart_data_out <= stub_rx;
                else if (rx_q.size() != 0) uart_data_out <= rx_q.pop_front();
            end
        end
        if (uart_read_enable && uart_active_address == 8'd4) begin
            tx_buf       = uart_data_in;
            tx_buf_valid = 1'b1;
        end
        // serialiser: start 0, LSB first, stop 1
        if (tx_bits == 0) begin
            line = 1'b1;
            if (tx_buf_valid) begin
                tx_sh        = {1'b1, tx_buf, 1'b0};
                tx_bits      = 10;
                tx_tick      = 0;
                tx_buf_valid = 1'b0;
            end
        end else begin
            line = tx_sh[0];
            tx_tick++;
            if (tx_tick == BAUD_DIV) begin
                tx_tick = 0;
                tx_sh   = tx_sh >> 1;
                tx_bits--;
            end
        end
        // deserialiser: mid-bit sampling after the falling start edge
        if (!rx_busy) begin
            if (!line) begin
                rx_busy = 1'b1;
                rx_tick = 0;
                rx_k    = 0;
            end
        end else begin
            rx_tick++;
            if (rx_tick == BAUD_DIV / 2 + rx_k * BAUD_DIV) begin
                rx_frame = {line, rx_frame[9:1]};
                rx_k++;
                if (rx_k == 10) begin
                    rx_busy    = 1'b0;
                    last_frame = rx_frame;
                    rx_q.push_back(rx_frame[8:1]);
                    frames++;
                end
            end
        end
    end

    // ---------------- bus / stream monitor ----------------
    int         cyc = 0;
    int         pushes = 0;
    int         rx_reads = 0;
    int         both_err = 0;
    int         stab_err = 0;
    int         last_poll_cyc = -100;
    int         poll_space = 0;
    int         mv_rise_frames = -1;
    logic [7:0] last_push = 8'h00;
    logic       prev_hold = 1'b0;
    logic       prev_mv = 1'b0;
    logic [7:0] prev_m_data = 8'h00;
    logic [7:0] got_q[$];

    always @(negedge clock) begin
        cyc++;
        if (uart_read_enable && uart_write_enable) both_err++;
        if (uart_read_enable && uart_active_address == 8'd4) begin
            pushes++;
            last_push = uart_data_in;
        end
        if (uart_write_enable && uart_active_address == 8'd5) begin
            poll_space    = cyc - last_poll_cyc - 1;
            last_poll_cyc = cyc;
        end
        if (uart_write_enable && uart_active_address == 8'd3) rx_reads++;
        if (prev_hold && m_data !== prev_m_data) stab_err++;
        if (m_valid && !prev_mv) mv_rise_frames = frames;
        prev_hold   = m_valid && !m_ready;
        prev_mv     = m_valid;
        prev_m_data = m_data;
        if (m_valid && m_ready) got_q.push_back(m_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clock);
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check("s_handshake", t < 2000, 1);
        @(negedge clock);
        s_valid = 1'b0;
        check("s_ready_low_while_full", s_ready, 0);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (got_q.size() < n && t < budget) begin
            @(negedge clock);
            t++;
        end
        check("rx_wait", t < budget, 1);
    endtask

    task automatic set_m_ready(input logic v);
        @(posedge clock);
        #1;
        m_ready = v;
    endtask

    task automatic wait_poll(input int budget);
        int t = 0;
        while (!(uart_write_enable && uart_active_address == 8'd5) && t < budget) begin
            @(negedge clock);
            t++;
        end
        check("poll_seen", t < budget, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int p0;
        int r0;

        // reset values
        repeat (3) @(negedge clock);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_strobes", {uart_read_enable, uart_write_enable}, 2'b00);
        check("rst_address", uart_active_address, 8'h00);
        check("rst_data_in", uart_data_in, 8'h00);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("rel_s_ready", s_ready, 1);

        // loopback, single byte
        set_m_ready(1'b1);
        send_byte(8'b0000_1010);
        wait_rx(1, 3000);
        check("lb_pushes", pushes, 1);
        check("lb_push_data", last_push, 8'h0A);
        check("lb_frame", last_frame, {1'b1, 8'h0A, 1'b0});
        check("lb_mvalid_after_frame", mv_rise_frames, 1);
        check("lb_m_data", got_q[0], 8'h0A);

        // loopback, back-to-back bytes
        got_q.delete();
        send_byte(8'b0000_1010);
        send_byte(8'b0011_1110);
        wait_rx(2, 4000);
        check("b2b_first", got_q[0], 8'h0A);
        check("b2b_second", got_q[1], 8'h3E);
        check("b2b_pushes", pushes, 3);

        // stubbed: TX buffer full, junk in unused status bits
        stub_mode   = 1'b1;
        stub_status = 8'hF1;
        stub_rx     = 8'h77;
        p0 = pushes;
        send_byte(8'h5A);
        repeat (100) @(negedge clock);
        check("full_no_push", pushes - p0, 0);
        check("poll_spacing", poll_space, POLL_GAP + 3);
        wait_poll(50);
        stub_status = 8'hF0;
        n = 0;
        while (!uart_read_enable && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("clear_push_latency_le5", n <= 5, 1);
        check("clear_push_addr", uart_active_address, 8'h04);
        check("clear_push_data", uart_data_in, 8'h5A);

        // RX priority over a waiting TX byte, with m_ready low
        set_m_ready(1'b0);
        stub_status = 8'h01;
        send_byte(8'hC3);
        repeat (10) @(negedge clock);
        r0 = rx_reads;
        stub_status = 8'h02;
        n = 0;
        while (!(uart_read_enable || (uart_write_enable && uart_active_address == 8'd3)) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("prio_first_is_rx", {uart_read_enable, uart_write_enable, uart_active_address}, {1'b0, 1'b1, 8'h03});
        @(negedge clock);
        n = 0;
        while (!uart_read_enable && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("prio_then_push", uart_read_enable, 1);
        check("prio_push_data", uart_data_in, 8'hC3);
        repeat (60) @(negedge clock);
        check("hold_single_rx_read", rx_reads - r0, 1);
        check("hold_m_valid", m_valid, 1);
        check("hold_m_data", m_data, 8'h77);
        check("hold_m_data_stable", stab_err, 0);

        // handshake releases the next RX read
        got_q.delete();
        set_m_ready(1'b1);
        n = 0;
        while (rx_reads - r0 < 2 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("rx_read_after_handshake", rx_reads - r0 >= 2, 1);
        check("handshake_data", got_q[0], 8'h77);
        stub_status = 8'h00;
        repeat (20) @(negedge clock);

        // reset during STAT_WAIT with both holds full
        set_m_ready(1'b0);
        stub_status = 8'h02;
        n = 0;
        while (!m_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("pre_rst_m_valid", m_valid, 1);
        stub_status = 8'h01;
        send_byte(8'h99);
        wait_poll(50);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_m_valid", m_valid, 0);
        check("async_rst_s_ready", s_ready, 0);
        check("async_rst_strobes", {uart_read_enable, uart_write_enable}, 2'b00);
        check("async_rst_address", uart_active_address, 8'h00);
        @(negedge clock);
        resetn      = 1'b1;
        stub_status = 8'h00;
        @(posedge clock);
        #1;
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_m_valid", m_valid, 0);
        p0 = pushes;
        repeat (40) @(negedge clock);
        check("rst_dropped_tx_byte", pushes - p0, 0);

        check("no_dual_strobe", both_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
